// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive controller driving an external SIPO register.
//
// Watches the serial line through a two-flop synchronizer. For each accepted
// frame it produces eight one-cycle shift_en pulses at the centre of each data
// bit, then checks the stop bit and captures the SIPO parallel output into
// rx_data with a valid/ready handshake.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between the last data bit and the stop bit. Without the macro there is no
// parity state and parity_err is tied low.
//
// Ports:
//   clk          single clock, all logic on posedge
//   reset        synchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   shift_en     one-cycle enable pulse to the SIPO register
//   sample_bit   sampled bit presented to the SIPO serial input
//   sipo_data    SIPO parallel output (LSB = first received bit)
//   rx_data      captured byte
//   rx_valid     rx_data holds an unacknowledged byte
//   rx_ready     consumer acknowledge
//   framing_err  one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch (parity build only)
//   overrun      sticky flag: a completed byte was dropped
//   busy         high whenever the receiver is not idle
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       shift_en,
  output logic       sample_bit,
  input  logic [7:0] sipo_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  function automatic logic parity_mismatch(input logic par_acc, input logic par_bit);
    return par_acc ^ par_bit;
  endfunction

  logic par_acc_r, par_acc_nx;
  logic par_bad_r, par_bad_nx;
  logic parity_err_r, parity_err_nx;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;
`endif

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [2:0]       bit_cnt_r, bit_cnt_nx;
  logic             rx_meta_r, rx_sync_r, rx_s;
  logic             shift_en_r, shift_en_nx;
  logic             sample_bit_r, sample_bit_nx;
  logic             framing_err_r, framing_err_nx;
  logic             load_s;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r, overrun_r, busy_r;

  assign rx_s = rx_sync_r;

  // Two-flop synchronizer; idles high so reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_nx       = state_r;
    cnt_nx         = cnt_r + CNT_ONE;
    bit_cnt_nx     = bit_cnt_r;
    shift_en_nx    = 1'b0;
    sample_bit_nx  = sample_bit_r;
    framing_err_nx = 1'b0;
    load_s         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_nx     = par_acc_r;
    par_bad_nx     = par_bad_r;
    parity_err_nx  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_nx = '0;
        if (!rx_s) begin
          state_nx   = ST_START;
          bit_cnt_nx = 3'd0;
`ifdef UART_RX_PARITY_EN
          par_acc_nx = 1'b0;
          par_bad_nx = 1'b0;
`endif
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (cnt_r == CNT_HALF) begin
          if (!rx_s) begin
            state_nx = ST_DATA;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          state_nx = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nx        = '0;
          shift_en_nx   = 1'b1;
          sample_bit_nx = rx_s;
`ifdef UART_RX_PARITY_EN
          par_acc_nx    = par_acc_r ^ rx_s;
`endif
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = ST_PARITY;
`else
            state_nx = ST_STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt_r + 3'd1;
          end
        end else begin
          state_nx = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          parity_err_nx = parity_mismatch(par_acc_r, rx_s);
          par_bad_nx    = parity_mismatch(par_acc_r, rx_s);
          state_nx      = ST_STOP;
        end else begin
          state_nx = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          if (rx_s) begin
            state_nx = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            load_s   = !par_bad_r;
`else
            load_s   = 1'b1;
`endif
          end else begin
            framing_err_nx = 1'b1;
            state_nx       = ST_WAIT_HIGH;
          end
        end else begin
          state_nx = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_nx = '0;
        if (rx_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
    // Every state starts timing its bit period from zero.
    cnt_nx = (state_nx != state_r) ? '0 : cnt_nx;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      bit_cnt_r     <= 3'd0;
      shift_en_r    <= 1'b0;
      sample_bit_r  <= 1'b0;
      framing_err_r <= 1'b0;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      overrun_r     <= 1'b0;
      busy_r        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_r     <= 1'b0;
      par_bad_r     <= 1'b0;
      parity_err_r  <= 1'b0;
`endif
    end else begin
      state_r       <= state_nx;
      cnt_r         <= cnt_nx;
      bit_cnt_r     <= bit_cnt_nx;
      shift_en_r    <= shift_en_nx;
      sample_bit_r  <= sample_bit_nx;
      framing_err_r <= framing_err_nx;
      busy_r        <= (state_nx != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      par_acc_r     <= par_acc_nx;
      par_bad_r     <= par_bad_nx;
      parity_err_r  <= parity_err_nx;
`endif
      // An acknowledge in the completion cycle frees the slot for the new byte.
      if (load_s) begin
        if (rx_valid_r && !rx_ready) begin
          overrun_r <= 1'b1;
        end else begin
          rx_data_r  <= sipo_data;
          rx_valid_r <= 1'b1;
        end
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign shift_en    = shift_en_r;
  assign sample_bit  = sample_bit_r;
  assign framing_err = framing_err_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign overrun     = overrun_r;
  assign busy        = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_r;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl (CLKS_PER_BIT = 16) with a behavioural SIPO.
// Stimulus pushes expected sample bits and expected accepted bytes into
// queues; a negedge monitor pops and compares them on shift_en pulses and on
// rx_valid/rx_ready handshakes.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LOAD_DLY = 2 * CPB;
`else
  localparam int LOAD_DLY = CPB;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       shift_en;
  logic       sample_bit;
  logic [7:0] sipo_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int pe_exp   = 0;

  logic       bit_q[$];
  logic [7:0] byte_q[$];
  logic       exp_bit;
  logic [7:0] exp_byte;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .shift_en(shift_en), .sample_bit(sample_bit), .sipo_data(sipo_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // SIPO register: shifts right, new bit enters at the MSB.
  always @(posedge clk) begin
    if (shift_en) sipo_data <= {sample_bit, sipo_data[7:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on shift pulses and on handshakes.
  always @(negedge clk) begin
    if (shift_en) begin
      if (bit_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL shift_extra: got pulse (sample_bit=%0b) expected none", sample_bit);
      end else begin
        exp_bit = bit_q.pop_front();
        check("sample_bit", {31'd0, sample_bit}, {31'd0, exp_bit});
      end
    end
    if (rx_valid && rx_ready) begin
      if (byte_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_extra: got rx_data 0x%0h expected no byte", rx_data);
      end else begin
        exp_byte = byte_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_byte});
      end
    end
    if (framing_err) fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit push);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    if (push) byte_q.push_back(d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par !== (^d)) tick(0);
`endif
    send_bit(stop);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  // Raise rx_ready for exactly the edge on which the next byte loads.
  task automatic ready_at_load();
    int seen = 0;
    int budget = 0;
    while (seen < 8 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (shift_en) seen++;
    end
    if (seen < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got %0d shift pulses expected 8", seen);
    end else begin
      repeat (LOAD_DLY - 1) @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_shift_en"},    {31'd0, shift_en},    32'd0);
    check({tag, "_sample_bit"},  {31'd0, sample_bit},  32'd0);
    check({tag, "_rx_data"},     {24'd0, rx_data},     32'd0);
    check({tag, "_rx_valid"},    {31'd0, rx_valid},    32'd0);
    check({tag, "_framing_err"}, {31'd0, framing_err}, 32'd0);
    check({tag, "_parity_err"},  {31'd0, parity_err},  32'd0);
    check({tag, "_overrun"},     {31'd0, overrun},     32'd0);
    check({tag, "_busy"},        {31'd0, busy},        32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0;
    rx = 1'b1;
    rx_ready = 1'b0;
    reset = 1'b1;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(4);

    // 0xA5 good frame, held until acknowledged.
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1);
    tick(4);
    check("a5_valid", {31'd0, rx_valid}, 32'd1);
    check("a5_busy", {31'd0, busy}, 32'd0);
    tick(10);
    check("a5_valid_hold", {31'd0, rx_valid}, 32'd1);
    pulse_ready();
    tick(1);
    check("a5_valid_clr", {31'd0, rx_valid}, 32'd0);

    // False start: 4-cycle low glitch.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("fs_busy", {31'd0, busy}, 32'd0);
    check("fs_bitq", bit_q.size(), 32'd0);
    check("fs_fe", fe_cnt, 32'd0);
    check("fs_valid", {31'd0, rx_valid}, 32'd0);

    // 0x3C with stop bit low: framing error, stays busy until line high.
    fe0 = fe_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
    tick(20);
    check("fe_pulse", fe_cnt, fe0 + 1);
    check("fe_valid", {31'd0, rx_valid}, 32'd0);
    check("fe_busy_low", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(5);
    check("fe_busy_high", {31'd0, busy}, 32'd0);

    // Overrun: 0x11 then 0x22 without acknowledge.
    send_frame(8'h11, ^8'h11, 1'b1, 1'b1);
    tick(4);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b0);
    tick(4);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ready();
    tick(2);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Acknowledge coinciding with the next load: no overrun.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("rst_ovr_clr", {31'd0, overrun}, 32'd0);
    send_frame(8'h11, ^8'h11, 1'b1, 1'b1);
    tick(4);
    fork
      send_frame(8'h22, ^8'h22, 1'b1, 1'b1);
      ready_at_load();
    join
    tick(4);
    check("same_cyc_ovr", {31'd0, overrun}, 32'd0);
    check("same_cyc_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ready();

    // Reset during the 4th data bit of an all-ones frame.
    for (int i = 0; i < 3; i++) bit_q.push_back(1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + 4);
    reset = 1'b1;
    tick(1);
    check_all_zero("midrst");
    reset = 1'b0;
    tick(60);
    check("midrst_bitq", bit_q.size(), 32'd0);
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b1);
    tick(4);
    check("5a_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ready();

`ifdef UART_RX_PARITY_EN
    // 0x07 needs parity bit 1; send 0 first.
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    pe_exp++;
    tick(4);
    check("par_bad_valid", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    tick(4);
    check("par_ok_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ready();
`endif

    tick(5);
    check("pe_count", pe_cnt, pe_exp);
    check("byteq_empty", byte_q.size(), 32'd0);
    check("bitq_empty", bit_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
